// File: rtl/cmp_display_scanner.sv
// rtl/cmp_display_scanner.sv - multiplexed 7-segment scanner for per-channel comparator results
module cmp_display_scanner #(
  parameter int CHANNELS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CHANNELS-1:0] in_gt,
  input  logic [CHANNELS-1:0] in_lt,
  input  logic [CHANNELS-1:0] in_eq,
  input  logic                blank,
  output logic [6:0]          segments,
  output logic [CHANNELS-1:0] digit_n
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0]       CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST = IW'(CHANNELS - 1);
  localparam logic [FW-1:0]       FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1);

  localparam logic [6:0] SYM_EQ   = 7'b0110111;
  localparam logic [6:0] SYM_GT   = 7'b0111001;
  localparam logic [6:0] SYM_LT   = 7'b0001111;
  localparam logic [6:0] SYM_DASH = 7'b0111111;
  localparam logic [6:0] SYM_OFF  = 7'b1111111;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       frm;
  logic                phase;
  logic                pending;
  logic [CHANNELS-1:0] sh_gt, sh_lt, sh_eq;
  logic [CHANNELS-1:0] dp_gt, dp_lt, dp_eq;

  logic       slot_tick;
  logic       frame_end;
  logic       accept;
  logic [6:0] cur_code;

  assign slot_tick = (cnt == CNT_LAST);
  assign frame_end = slot_tick && (idx == IDX_LAST);
  assign in_ready  = ~pending;
  assign accept    = in_valid && in_ready;

  // Illegal flag combinations (two or more set) blink between DASH and OFF.
  always_comb begin
    cur_code = SYM_DASH;
    case ({dp_gt[idx], dp_lt[idx], dp_eq[idx]})
      3'b100:  cur_code = SYM_GT;
      3'b010:  cur_code = SYM_LT;
      3'b001:  cur_code = SYM_EQ;
      3'b000:  cur_code = SYM_DASH;
      default: cur_code = phase ? SYM_DASH : SYM_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      frm      <= '0;
      phase    <= 1'b0;
      pending  <= 1'b0;
      sh_gt    <= '0;
      sh_lt    <= '0;
      sh_eq    <= '0;
      dp_gt    <= '0;
      dp_lt    <= '0;
      dp_eq    <= '0;
      segments <= SYM_OFF;
      digit_n  <= '1;
    end else begin
      cnt <= slot_tick ? '0 : cnt + 1'b1;
      if (slot_tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      if (frame_end) begin
        if (frm == FRM_LAST) begin
          frm   <= '0;
          phase <= ~phase;
        end else begin
          frm <= frm + 1'b1;
        end
      end

      // Display only changes at a frame boundary so a frame never mixes old and new data.
      if (frame_end && pending) begin
        dp_gt   <= sh_gt;
        dp_lt   <= sh_lt;
        dp_eq   <= sh_eq;
        pending <= 1'b0;
      end else if (accept) begin
        sh_gt   <= in_gt;
        sh_lt   <= in_lt;
        sh_eq   <= in_eq;
        pending <= 1'b1;
      end

      segments <= blank ? SYM_OFF : cur_code;
      digit_n  <= blank ? '1 : ~(ONE_HOT0 << idx);
    end
  end

endmodule

// File: tb/tb_cmp_display_scanner.sv
// tb/tb_cmp_display_scanner.sv - randomized self-checking bench for cmp_display_scanner
module tb_cmp_display_scanner;

  localparam logic [6:0] EQ   = 7'b0110111;
  localparam logic [6:0] GT   = 7'b0111001;
  localparam logic [6:0] LT   = 7'b0001111;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_gt = '0, in_lt = '0, in_eq = '0;
  logic       blank = 1'b0;
  logic [6:0] segments;
  logic [3:0] digit_n;

  int vectors = 0;
  int errors = 0;

  // Reference model: cycles since reset release plus shadow/display/pending contents.
  int         k = 0;
  logic [3:0] m_sh_gt = '0, m_sh_lt = '0, m_sh_eq = '0;
  logic [3:0] m_dp_gt = '0, m_dp_lt = '0, m_dp_eq = '0;
  bit         m_pend = 1'b0;
  logic [6:0] exp_seg = OFF;
  logic [3:0] exp_dig = 4'hF;
  logic       exp_ready = 1'b1;

  cmp_display_scanner #(
    .CHANNELS(4),
    .REFRESH_DIV(4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_gt(in_gt),
    .in_lt(in_lt),
    .in_eq(in_eq),
    .blank(blank),
    .segments(segments),
    .digit_n(digit_n)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] sym(input bit g, input bit l, input bit e, input bit ph);
    int n;
    n = int'(g) + int'(l) + int'(e);
    if (n == 0) return DASH;
    if (n > 1) return ph ? DASH : OFF;
    if (g) return GT;
    if (l) return LT;
    return EQ;
  endfunction

  // Advances the model by one clock using pre-edge state, then waits past the edge.
  task automatic clk_step();
    int idx;
    bit fe, ph;
    idx = (k / 4) % 4;
    fe  = (k % 16) == 15;
    ph  = ((k / 16) / 2) % 2 == 1;
    if (blank) begin
      exp_seg = OFF;
      exp_dig = 4'hF;
    end else begin
      exp_seg = sym(m_dp_gt[idx], m_dp_lt[idx], m_dp_eq[idx], ph);
      exp_dig = ~(4'b0001 << idx);
    end
    if (fe && m_pend) begin
      m_dp_gt = m_sh_gt;
      m_dp_lt = m_sh_lt;
      m_dp_eq = m_sh_eq;
      m_pend  = 1'b0;
    end else if (in_valid && !m_pend) begin
      m_sh_gt = in_gt;
      m_sh_lt = in_lt;
      m_sh_eq = in_eq;
      m_pend  = 1'b1;
    end
    k++;
    exp_ready = !m_pend;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    k = 0;
    m_pend = 1'b0;
    m_sh_gt = '0; m_sh_lt = '0; m_sh_eq = '0;
    m_dp_gt = '0; m_dp_lt = '0; m_dp_eq = '0;
    exp_ready = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (in_ready !== 1'b1 || segments !== OFF || digit_n !== 4'hF) begin
      errors++;
      $display("FAIL reset_state rdy=%b seg=%b dig=%b want rdy=1 seg=%b dig=1111", in_ready, segments, digit_n, OFF);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    for (int i = 0; i < 40; i++) begin
      clk_step();
      vectors++;
      if (segments !== exp_seg || digit_n !== exp_dig || in_ready !== exp_ready) begin
        errors++;
        $display("FAIL idle_scan k=%0d seg=%b dig=%b rdy=%b want seg=%b dig=%b rdy=%b", k, segments, digit_n, in_ready, exp_seg, exp_dig, exp_ready);
      end
    end
  endtask

  task automatic test_update();
    logic [6:0] want;
    while (k % 16 != 6 || m_pend) clk_step();
    in_gt = 4'b0001; in_lt = 4'b0010; in_eq = 4'b0100; in_valid = 1'b1;
    clk_step();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL update_ready_low rdy=%b want 0", in_ready);
    end
    while (k % 16 != 0) begin
      clk_step();
      vectors++;
      if (segments !== exp_seg || digit_n !== exp_dig || in_ready !== exp_ready) begin
        errors++;
        $display("FAIL update_wait k=%0d seg=%b dig=%b rdy=%b want seg=%b dig=%b rdy=%b", k, segments, digit_n, in_ready, exp_seg, exp_dig, exp_ready);
      end
    end
    for (int i = 0; i < 16; i++) begin
      clk_step();
      if (k % 4 == 1) begin
        case ((k % 16) / 4)
          0: want = GT;
          1: want = LT;
          2: want = EQ;
          default: want = DASH;
        endcase
        vectors++;
        if (segments !== want || digit_n !== ~(4'b0001 << ((k % 16) / 4)) || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL update_frame k=%0d seg=%b dig=%b rdy=%b want seg=%b", k, segments, digit_n, in_ready, want);
        end
      end
    end
  endtask

  task automatic test_ignore();
    while (m_pend) clk_step();
    in_gt = 4'b1000; in_lt = 4'b0000; in_eq = 4'b0001; in_valid = 1'b1;
    clk_step();
    in_gt = 4'b0110; in_lt = 4'b1001; in_eq = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      if (!m_pend) in_valid = 1'b0;
      clk_step();
      vectors++;
      if (segments !== exp_seg || digit_n !== exp_dig || in_ready !== exp_ready) begin
        errors++;
        $display("FAIL ignore k=%0d seg=%b dig=%b rdy=%b want seg=%b dig=%b rdy=%b", k, segments, digit_n, in_ready, exp_seg, exp_dig, exp_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_coincident();
    while (k % 16 != 15 || m_pend) clk_step();
    in_gt = 4'b0000; in_lt = 4'b1111; in_eq = 4'b0000; in_valid = 1'b1;
    clk_step();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL coincident_ready rdy=%b want 0", in_ready);
    end
    for (int i = 0; i < 40; i++) begin
      clk_step();
      vectors++;
      if (segments !== exp_seg || digit_n !== exp_dig || in_ready !== exp_ready) begin
        errors++;
        $display("FAIL coincident k=%0d seg=%b dig=%b rdy=%b want seg=%b dig=%b rdy=%b", k, segments, digit_n, in_ready, exp_seg, exp_dig, exp_ready);
      end
    end
  endtask

  task automatic test_blink();
    while (m_pend) clk_step();
    in_gt = 4'b0010; in_lt = 4'b0000; in_eq = 4'b0010; in_valid = 1'b1;
    clk_step();
    in_valid = 1'b0;
    for (int i = 0; i < 90; i++) begin
      clk_step();
      vectors++;
      if (segments !== exp_seg || digit_n !== exp_dig || in_ready !== exp_ready) begin
        errors++;
        $display("FAIL blink k=%0d seg=%b dig=%b rdy=%b want seg=%b dig=%b rdy=%b", k, segments, digit_n, in_ready, exp_seg, exp_dig, exp_ready);
      end
    end
  endtask

  task automatic test_blank();
    blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      vectors++;
      if (segments !== OFF || digit_n !== 4'hF) begin
        errors++;
        $display("FAIL blank_off seg=%b dig=%b want seg=%b dig=1111", segments, digit_n, OFF);
      end
    end
    blank = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clk_step();
      vectors++;
      if (segments !== exp_seg || digit_n !== exp_dig || in_ready !== exp_ready) begin
        errors++;
        $display("FAIL blank_resume k=%0d seg=%b dig=%b want seg=%b dig=%b", k, segments, digit_n, exp_seg, exp_dig);
      end
    end
  endtask

  task automatic test_reset_pending();
    while (m_pend) clk_step();
    while (k % 16 != 5) clk_step();
    in_gt = 4'b1111; in_lt = 4'b0000; in_eq = 4'b0000; in_valid = 1'b1;
    clk_step();
    in_valid = 1'b0;
    clk_step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || segments !== OFF || digit_n !== 4'hF) begin
      errors++;
      $display("FAIL reset_pending_during rdy=%b seg=%b dig=%b want rdy=1 seg=%b dig=1111", in_ready, segments, digit_n, OFF);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clk_step();
    vectors++;
    if (segments !== DASH || digit_n !== 4'b1110 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_pending_first seg=%b dig=%b rdy=%b want seg=%b dig=1110 rdy=1", segments, digit_n, in_ready, DASH);
    end
    for (int i = 0; i < 40; i++) begin
      clk_step();
      vectors++;
      if (segments !== exp_seg || digit_n !== exp_dig || in_ready !== exp_ready) begin
        errors++;
        $display("FAIL reset_pending_after k=%0d seg=%b dig=%b rdy=%b want seg=%b dig=%b rdy=%b", k, segments, digit_n, in_ready, exp_seg, exp_dig, exp_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom % 4) == 0;
      in_gt    = 4'($urandom);
      in_lt    = 4'($urandom);
      in_eq    = 4'($urandom);
      blank    = ($urandom % 16) == 0;
      clk_step();
      vectors++;
      if (segments !== exp_seg || digit_n !== exp_dig || in_ready !== exp_ready) begin
        errors++;
        $display("FAIL random k=%0d seg=%b dig=%b rdy=%b want seg=%b dig=%b rdy=%b", k, segments, digit_n, in_ready, exp_seg, exp_dig, exp_ready);
      end
    end
    in_valid = 1'b0;
    blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_update();
    test_ignore();
    test_coincident();
    test_blink();
    test_blank();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cmp_display_scanner.md
CMP_DISPLAY_SCANNER -- requirements
Module: cmp_display_scanner

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of comparator results and digits shown (legal range 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (legal minimum 2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (legal minimum 1).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  new result set offered.
REQ-007 in_ready  output  1  block can accept a result set.
REQ-008 in_gt  input  CHANNELS  per-channel A>B flag.
REQ-009 in_lt  input  CHANNELS  per-channel A<B flag.
REQ-010 in_eq  input  CHANNELS  per-channel A=B flag.
REQ-011 blank  input  1  display off while high.
REQ-012 segments  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-013 digit_n  output  CHANNELS  active-low digit enable, registered, at most one bit low.

Function
REQ-014 Symbol codes SHALL be: EQ 7'b0110111, GT 7'b0111001, LT 7'b0001111, DASH 7'b0111111, OFF 7'b1111111.
REQ-015 Per-channel decode SHALL be: exactly one of gt/lt/eq set -> GT/LT/EQ; none set -> DASH; two or more set -> ERR (blinking DASH).
REQ-016 Handshake SHALL be: transfer on in_valid && in_ready; flags captured into a shadow register; in_ready deasserts the next cycle.
REQ-017 in_valid while in_ready low SHALL be ignored and SHALL NOT alter the shadow register.
REQ-018 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; the cycle at REFRESH_DIV-1 is a slot tick.
REQ-019 Digit index SHALL advance on each slot tick, 0..CHANNELS-1, wrapping to 0; frame_end = slot tick while index is CHANNELS-1.
REQ-020 On frame_end with an update pending, shadow SHALL copy to the display register; in_ready reasserts the following cycle. Updates SHALL NOT tear mid-frame.
REQ-021 A transfer accepted in the same cycle as frame_end SHALL NOT apply at that frame_end; it SHALL apply at the next one.
REQ-022 Blink phase SHALL toggle after every BLINK_FRAMES frame_ends; ERR channels show DASH when phase=1 and OFF when phase=0.
REQ-023 segments/digit_n SHALL be registered from the current index and display register, with 1-cycle latency after an index change.
REQ-024 For index i, digit_n SHALL have only bit i low, and segments SHALL carry channel i's code.
REQ-025 blank=1 SHALL force segments=OFF and digit_n all ones on the next cycle; the scan, blink and handshake keep running.
REQ-026 With CHANNELS=1, the index SHALL stay 0 and every slot tick SHALL be a frame_end.

Reset
REQ-027 rst_n low SHALL immediately clear: refresh counter 0, index 0, blink phase 0, pending 0, shadow 0, display register all-zero flags (all channels DASH).
REQ-028 During reset, outputs SHALL be: in_ready 1, segments 7'b1111111, digit_n all ones.
REQ-029 Reset asserted mid-update SHALL discard the pending shadow; after release the first registered output is digit 0 showing DASH.

Verification (CHANNELS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-030 Reset release with no input -> digit_n cycles 1110,1101,1011,0111 every 4 clocks, 1 cycle after each index change; segments 7'b0111111 throughout.
REQ-031 Accept gt=0001, lt=0010, eq=0100 mid-frame -> in_ready low until the cycle after frame_end; next frame shows digit0 7'b0111001, digit1 7'b0001111, digit2 7'b0110111, digit3 7'b0111111.
REQ-032 in_valid held while in_ready low with different flags -> ignored; display matches the first accepted set.
REQ-033 Transfer coincident with frame_end -> old data shown for one more full frame, new data shown after the next frame_end.
REQ-034 Channel 1 with gt=1 and eq=1 -> digit1 alternates OFF (frames 0-1) and 7'b0111111 (frames 2-3); other channels steady.
REQ-035 blank pulsed 3 cycles, and separately rst_n pulsed while pending -> all-off outputs during blank with the index still advancing; after reset, in_ready 1 and all digits DASH.
